// File: rtl/mult_div_unit.sv
// Iterative HI/LO unit: MULT/MULTU (shift-add), DIV/DIVU (restoring), MFHI/MFLO/MTHI/MTLO.
// Define MDU_FAST_MULT_EN to replace the 32-cycle multiply with a single-cycle product.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, next_state;
  logic [31:0] op_a, op_b, raw_a;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic        neg_q, neg_r, is_mul_q, div_zero;

  logic        is_mul_op, is_div_op, is_signed_op, start;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_trial;
  logic [63:0] mul_step, div_step, prod_fix;
  logic [31:0] quot_fix, rem_fix;

  assign is_mul_op    = (funct == F_MULT) || (funct == F_MULTU);
  assign is_div_op    = (funct == F_DIV)  || (funct == F_DIVU);
  assign is_signed_op = (funct == F_MULT) || (funct == F_DIV);
  assign start        = (state == IDLE) && (is_mul_op || is_div_op) && !flush;

  assign a_neg = is_signed_op && operand_a[31];
  assign b_neg = is_signed_op && operand_b[31];
  assign a_mag = a_neg ? (~operand_a + 32'd1) : operand_a;
  assign b_mag = b_neg ? (~operand_b + 32'd1) : operand_b;

  // acc = {partial product, unshifted multiplier bits}; one multiplier bit retired per cycle.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, op_a} : 33'd0);
  assign mul_step = {mul_sum, acc[31:1]};

  // acc = {remainder, dividend/quotient}; the trial's top bit set means the subtract failed.
  assign div_trial = {acc[63:32], acc[31]} - {1'b0, op_b};
  assign div_step  = div_trial[32] ? {acc[62:0], 1'b0}
                                   : {div_trial[31:0], acc[30:0], 1'b1};

  assign prod_fix = neg_q ? (~acc + 64'd1) : acc;
  assign quot_fix = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem_fix  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: each always_comb assigns a default first so no path leaves a signal unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) begin
`ifdef MDU_FAST_MULT_EN
        next_state = is_div_op ? DIV : DONE;
`else
        next_state = is_div_op ? DIV : MUL;
`endif
      end
      MUL, DIV: begin
        if (flush)             next_state = IDLE;
        else if (cnt == 5'd31) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stall_req = start || (state == MUL) || (state == DIV);
    busy      = (state != IDLE);
    result    = 32'd0;
    if (funct == F_MFHI)      result = hi;
    else if (funct == F_MFLO) result = lo;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_a     <= '0;
      op_b     <= '0;
      raw_a    <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_mul_q <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a     <= a_mag;
            op_b     <= b_mag;
            raw_a    <= operand_a;
            cnt      <= '0;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            is_mul_q <= is_mul_op;
            div_zero <= (operand_b == 32'd0);
`ifdef MDU_FAST_MULT_EN
            acc <= is_mul_op ? ({32'd0, a_mag} * {32'd0, b_mag}) : {32'd0, a_mag};
`else
            acc <= is_mul_op ? {32'd0, b_mag} : {32'd0, a_mag};
`endif
          end else if (!flush) begin
            if (funct == F_MTHI) hi <= operand_a;
            if (funct == F_MTLO) lo <= operand_a;
          end
        end
        MUL: begin
          acc <= mul_step;
          cnt <= cnt + 5'd1;
        end
        DIV: begin
          acc <= div_step;
          cnt <= cnt + 5'd1;
        end
        DONE: begin
          if (!flush) begin
            if (is_mul_q) begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end else if (div_zero) begin
              hi <= raw_a;
              lo <= 32'hFFFF_FFFF;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: scoreboard of expected {HI,LO}, stall-length checks,
// flush/reset abort, MT/MF forwarding.
module tb_mult_div_unit;

  localparam logic [5:0] F_NOP   = 6'h00;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk, rst, flush;
  logic [5:0]  funct;
  logic [31:0] operand_a, operand_b;
  logic        stall_req, busy;
  logic [31:0] result, hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  mult_div_unit dut (
    .clk(clk), .rst(rst), .funct(funct), .operand_a(operand_a), .operand_b(operand_b),
    .flush(flush), .stall_req(stall_req), .busy(busy), .result(result), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] t, u;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (f)
      F_MULT:  begin t = sa * sb; return t; end
      F_MULTU: return {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        t = sa / sb;
        u = sa % sb;
        return {u[31:0], t[31:0]};
      end
      F_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int exp_stall(input logic [5:0] f);
`ifdef MDU_FAST_MULT_EN
    if (f == F_MULT || f == F_MULTU) return 1;
`endif
    return 33;
  endfunction

  // Entered and left just after a rising edge.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int stall_cnt;
    bit saw_done;
    e = model(f, a, b);
    exp_q.push_back(e);
    funct = f; operand_a = a; operand_b = b;
    stall_cnt = 0;
    saw_done  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall_req) stall_cnt++;
      else begin saw_done = 1; break; end
    end
    check("stall_cycles", 64'(stall_cnt), 64'(exp_stall(f)));
    check("done_seen", 64'(saw_done), 64'd1);
    check("done_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    funct = F_MFHI;
    @(negedge clk);
    e = exp_q.pop_front();
    check("hi", 64'(hi), 64'(e[63:32]));
    check("lo", 64'(lo), 64'(e[31:0]));
    check("mfhi_result", 64'(result), 64'(e[63:32]));
    check("mfhi_nostall", 64'(stall_req), 64'd0);
    check("idle_after", 64'(busy), 64'd0);
    model_hi = e[63:32];
    model_lo = e[31:0];
    @(posedge clk); #1;
    funct = F_MFLO;
    @(negedge clk);
    check("mflo_result", 64'(result), 64'(e[31:0]));
    @(posedge clk); #1;
    funct = F_NOP;
  endtask

  // Start a DIV and kill it at cycle 10 with either flush or reset.
  task automatic abort_op(input bit use_rst);
    funct = F_DIV; operand_a = 32'd1000; operand_b = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    funct = F_NOP;
    if (use_rst) rst = 1'b0; else flush = 1'b1;
    @(negedge clk);
    check("abort_mid_stall", 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b0;
    if (use_rst) begin model_hi = 32'd0; model_lo = 32'd0; end
    @(negedge clk);
    check(use_rst ? "rst_busy" : "flush_busy", 64'(busy), 64'd0);
    check(use_rst ? "rst_stall" : "flush_stall", 64'(stall_req), 64'd0);
    check(use_rst ? "rst_hi" : "flush_hi", 64'(hi), 64'(model_hi));
    check(use_rst ? "rst_lo" : "flush_lo", 64'(lo), 64'(model_lo));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [5:0] ops [4];
    logic [5:0] f;
    logic [31:0] a, b;
    ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;
    rst = 1'b0; flush = 1'b0; funct = F_NOP; operand_a = '0; operand_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall_req", 64'(stall_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(F_MULT,  32'hFFFF_FFFD, 32'd7);
    run_op(F_DIV,   32'hFFFF_FFF9, 32'd2);
    run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(F_DIVU,  32'h1234_5678, 32'd0);
    run_op(F_DIV,   32'h8765_4321, 32'd0);
    run_op(F_MULT,  32'h8000_0000, 32'h8000_0000);
    run_op(F_DIV,   32'd7, 32'hFFFF_FFFE);

    abort_op(1'b0);
    abort_op(1'b1);

    // MTHI then MFHI back to back, neither stalls.
    funct = F_MTHI; operand_a = 32'hCAFE_F00D;
    @(negedge clk);
    check("mthi_nostall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    funct = F_MFHI; operand_a = 32'd0;
    model_hi = 32'hCAFE_F00D;
    @(negedge clk);
    check("mfhi_fwd", 64'(result), 64'(model_hi));
    check("mfhi_fwd_nostall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    funct = F_MTLO; operand_a = 32'h1357_9BDF;
    @(posedge clk); #1;
    model_lo = 32'h1357_9BDF;
    funct = F_MTLO; operand_a = 32'hDEAD_BEEF; flush = 1'b1;
    @(posedge clk); #1;
    funct = F_MFLO; flush = 1'b0;
    @(negedge clk);
    check("mtlo_flushed", 64'(result), 64'(model_lo));
    check("mtlo_hi_kept", 64'(hi), 64'(model_hi));
    @(posedge clk); #1;
    funct = F_NOP;

    // Flushed start in IDLE must not launch an operation.
    funct = F_DIV; operand_a = 32'd9; operand_b = 32'd3; flush = 1'b1;
    @(negedge clk);
    check("flush_start_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    funct = F_NOP; flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      f = ops[$urandom_range(0, 3)];
      a = $urandom();
      b = (i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 300));
      if (i == 5) b = 32'hFFFF_FFFF;
      run_op(f, a, b);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Execute-stage HI/LO unit that consumes the 6-bit FUNCT code produced by the decode stage for `OP_SPECIAL` instructions. It performs MULT/MULTU/DIV/DIVU iteratively, owns the architectural HI and LO registers, and services MFHI/MFLO/MTHI/MTLO. While an operation is in flight it raises a stall request to the pipeline controller.

## Interface
Parameters:
- none; all widths come from `bus.v` (`FUNCT_BUS` = 6 bits, `DATA_BUS` = 32 bits) and opcodes from `funct.v`.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- funct  in  6  FUNCT of the instruction currently in EX; non-HI/LO codes are no-ops here.
- operand_a  in  32  rs value (dividend / multiplicand / MTHI/MTLO source).
- operand_b  in  32  rt value (divisor / multiplier).
- flush  in  1  pipeline flush; aborts the current operation.
- stall_req  out  1  hold EX and all earlier stages.
- busy  out  1  state != IDLE.
- result  out  32  HI for MFHI, LO for MFLO, otherwise 0 (combinational).
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.

## Operation
- Decoded FUNCT values: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
- `start` = state IDLE, funct is one of MULT/MULTU/DIV/DIVU, flush low.
- States: IDLE, MUL, DIV, DONE.
  - IDLE: on `start`, latch |a| and |b| (magnitudes for the signed ops, raw values for the unsigned ops), latch the sign flags, clear the counter, and move to MUL or DIV. On MTHI/MTLO with flush low, write operand_a to HI/LO at this edge.
  - MUL: radix-2 shift-add, one bit per cycle, counter 0..31. When the counter reaches 31, move to DONE.
  - DIV: restoring division, one quotient bit per cycle, counter 0..31. When the counter reaches 31, move to DONE.
  - DONE: apply the sign fixup, write {HI,LO}, return to IDLE unconditionally. funct is ignored in this state; the same instruction is still present in EX and must not restart the operation.
- Signed fixup:
  - Product: negate the 64-bit product if the operand signs differ.
  - Quotient: negate if the operand signs differ.
  - Remainder: takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF with DIV: LO=0x80000000, HI=0.
- Divide by zero, either signedness: the full 32 cycles still run. LO=0xFFFFFFFF, HI=operand_a, no sign fixup.
- flush high in MUL/DIV/DONE: next state IDLE, HI/LO unchanged.
- flush high in IDLE: suppresses start and MT writes.
- rst low at any point: state IDLE, counter 0, HI=LO=0, datapath registers 0. This includes a reset arriving mid-operation.

## Timing
- Reset values: stall_req=0, busy=0, result=0, hi=0, lo=0.
- stall_req = start | state==MUL | state==DIV. It is combinational, so it is asserted in the same cycle the MULT/DIV reaches EX.
- Cycle numbering for an operation where cycle 0 is the start cycle:
  - Cycles 1–32: MUL/DIV.
  - Cycle 33: DONE, with stall_req low.
  - HI/LO are visible from cycle 34.
  - stall_req is high for 33 cycles.
- The pipeline advances at the end of DONE, so the following instruction sees IDLE and reads the updated HI/LO.
- MTHI/MTLO: single cycle, no stall, visible the next cycle.
- MFHI/MFLO: no stall.
- A back-to-back MFHI following an MTHI reads the new value, because the write is registered before the MFHI reaches EX.

## Configuration
- `MDU_FAST_MULT_EN` defined:
  - MULT/MULTU compute a single-cycle 32×32 product in IDLE, latch it, and go directly to DONE.
  - stall_req is high for the start cycle only.
  - HI/LO are visible 2 cycles after start.
  - The MUL state is unused.
- Undefined: iterative 32-cycle multiply as described above.
- Divide behaviour is identical in both builds.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> stall_req high exactly 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001. With `MDU_FAST_MULT_EN`: 1 stall cycle, same result.
- MULT a=0xFFFFFFFD (-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=0x12345678 b=0 -> 33 stall cycles, LO=0xFFFFFFFF, HI=0x12345678.
- Start DIV, assert flush at cycle 10 -> IDLE next cycle, stall_req low, HI/LO unchanged. Repeat with rst low at cycle 10 -> HI=LO=0.
- MTHI 0xCAFEF00D, then MFHI next cycle -> result=0xCAFEF00D, no stall. MTLO with flush high -> LO unchanged.
